testbasic9_producer: RTL and testbench



---
 rtl/testbasic9_producer_pkg.sv | 28 ++
 rtl/testbasic9_producer.sv | 77 +++++++
 tb/tb_testbasic9_producer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/testbasic9_producer_pkg.sv
// Shared types for the TestBasic9 producer stage: FSM states, integer limits and the offset adder.
// Build option: define TESTBASIC9_PRODUCER_SAT_EN to make add_offset saturate instead of wrap.
package testbasic9_types;

    typedef enum logic [0:0] {
        ST_READ  = 1'b0,
        ST_WRITE = 1'b1
    } testbasic9_producer_state_t;

    localparam int TESTBASIC9_INT_MAX = 32'sh7FFF_FFFF;
    localparam int TESTBASIC9_INT_MIN = 32'sh8000_0000;

    function automatic int add_offset(input int a, input int off);
`ifdef TESTBASIC9_PRODUCER_SAT_EN
        logic [32:0] sum;
        sum = {a[31], a} + {off[31], off};
        // Sign-extended bits disagreeing means the true sum left the 32-bit range.
        if (sum[32] != sum[31]) begin
            return sum[32] ? TESTBASIC9_INT_MIN : TESTBASIC9_INT_MAX;
        end else begin
            return $signed(sum[31:0]);
        end
`else
        return a + off;
`endif
    endfunction

endpackage

// File: rtl/testbasic9_producer.sv
// Producer stage of TestBasic9: reads a sample, adds OFFSET, forwards it and counts transfers.
// Build option: TESTBASIC9_PRODUCER_SAT_EN selects a saturating add (see package).
module testbasic9_producer
    import testbasic9_types::*;
#(
    parameter int OFFSET = 32'sd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a_in,
    input  logic        a_in_sync,
    output logic        a_in_notify,
    output logic [31:0] b_out,
    input  logic        b_out_sync,
    output logic        b_out_notify,
    output logic [31:0] m_out
);

    testbasic9_producer_state_t state_q, state_d;
    logic [31:0] b_out_q, b_out_d;
    logic [31:0] m_out_q, m_out_d;
    logic        a_notify_q, a_notify_d;
    logic        b_notify_q, b_notify_d;

    // Next-state, data capture and transfer counting; only the sync matching the state is honoured.
    always_comb begin
        state_d = state_q;
        b_out_d = b_out_q;
        m_out_d = m_out_q;
        case (state_q)
            ST_READ: begin
                if (a_in_sync) begin
                    state_d = ST_WRITE;
                    b_out_d = add_offset(a_in, OFFSET);
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                if (b_out_sync) begin
                    state_d = ST_READ;
                    m_out_d = m_out_q + 32'd1;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            default: begin
                state_d = ST_READ;
            end
        endcase
        a_notify_d = (state_d == ST_READ);
        b_notify_d = (state_d == ST_WRITE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_READ;
            b_out_q    <= 32'd0;
            m_out_q    <= 32'd0;
            a_notify_q <= 1'b1;
            b_notify_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            b_out_q    <= b_out_d;
            m_out_q    <= m_out_d;
            a_notify_q <= a_notify_d;
            b_notify_q <= b_notify_d;
        end
    end

    assign a_in_notify  = a_notify_q;
    assign b_out_notify = b_notify_q;
    assign b_out        = b_out_q;
    assign m_out        = m_out_q;

endmodule

// File: tb/tb_testbasic9_producer.sv
// Self-checking bench for testbasic9_producer: directed vector table, hand sequences, stream and random traffic.
module tb_testbasic9_producer;

    logic        clk;
    logic        rst;
    logic [31:0] a_in;
    logic        a_in_sync;
    logic        a_in_notify;
    logic [31:0] b_out;
    logic        b_out_sync;
    logic        b_out_notify;
    logic [31:0] m_out;

    int n_cmp;
    int n_bad;

    // Reference model: a queue holding at most the one sample waiting to go downstream.
    int mq[$];
    int m_last;
    int m_cnt;

    typedef struct {
        int a;
        bit as;
        bit bs;
        bit exp_an;
        bit exp_bn;
        int exp_bout;
        int exp_m;
    } vec_t;

    vec_t vecs[15];

    testbasic9_producer dut (
        .clk          (clk),
        .rst          (rst),
        .a_in         (a_in),
        .a_in_sync    (a_in_sync),
        .a_in_notify  (a_in_notify),
        .b_out        (b_out),
        .b_out_sync   (b_out_sync),
        .b_out_notify (b_out_notify),
        .m_out        (m_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_add(input int a);
        longint s;
        s = longint'(a) + 64'sd1;
`ifdef TESTBASIC9_PRODUCER_SAT_EN
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
        return int'(s);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_last = 0;
        m_cnt  = 0;
    endtask

    task automatic model_step(input int a, input bit as, input bit bs);
        if (mq.size() == 0) begin
            if (as) mq.push_back(ref_add(a));
        end else if (bs) begin
            m_last = mq.pop_front();
            m_cnt++;
        end
    endtask

    task automatic check(input string name, input bit an, input bit bn, input int bo, input int m);
        n_cmp++;
        if (a_in_notify !== an || b_out_notify !== bn || b_out !== bo || m_out !== m) begin
            n_bad++;
            $display("FAIL %s: got an=%0b bn=%0b b_out=%0d m_out=%0d, expected an=%0b bn=%0b b_out=%0d m_out=%0d",
                     name, a_in_notify, b_out_notify, $signed(b_out), m_out, an, bn, bo, m);
        end
    endtask

    task automatic check_model(input string name);
        check(name, mq.size() == 0, mq.size() != 0, (mq.size() != 0) ? mq[0] : m_last, m_cnt);
    endtask

    // Drive at the falling edge, let one rising edge happen, return at the next falling edge.
    task automatic cycle(input int a, input bit as, input bit bs);
        a_in       = a;
        a_in_sync  = as;
        b_out_sync = bs;
        @(posedge clk);
        model_step(a, as, bs);
        @(negedge clk);
    endtask

    initial begin
        int got[$];
        int nxt;
        int budget;
        bit consumed;
        bit ok;

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        a_in = 32'd0;
        a_in_sync = 1'b0;
        b_out_sync = 1'b0;
        model_reset();

        vecs[0]  = '{41, 1'b1, 1'b0, 1'b0, 1'b1, 42, 0};
        vecs[1]  = '{5, 1'b1, 1'b0, 1'b0, 1'b1, 42, 0};
        vecs[2]  = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 42, 1};
        vecs[3]  = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 42, 1};
        vecs[4]  = '{10, 1'b1, 1'b1, 1'b0, 1'b1, 11, 1};
        for (int i = 5; i < 10; i++) vecs[i] = '{99, 1'b0, 1'b0, 1'b0, 1'b1, 11, 1};
        vecs[10] = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 11, 2};
`ifdef TESTBASIC9_PRODUCER_SAT_EN
        vecs[11] = '{32'sh7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 32'sh7FFF_FFFF, 2};
        vecs[12] = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 32'sh7FFF_FFFF, 3};
`else
        vecs[11] = '{32'sh7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 32'sh8000_0000, 2};
        vecs[12] = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 32'sh8000_0000, 3};
`endif
        vecs[13] = '{-1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 3};
        vecs[14] = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 4};

        @(negedge clk);
        @(negedge clk);
        check("reset_state", 1'b1, 1'b0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].a, vecs[i].as, vecs[i].bs);
            check($sformatf("vec%0d", i), vecs[i].exp_an, vecs[i].exp_bn, vecs[i].exp_bout, vecs[i].exp_m);
        end

        // Reset while a sample is waiting downstream.
        cycle(7, 1'b1, 1'b0);
        check("pre_reset_write", 1'b0, 1'b1, 8, 4);
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        check("reset_mid_write", 1'b1, 1'b0, 0, 0);
        rst = 1'b0;
        cycle(0, 1'b0, 1'b1);
        check("after_reset_read", 1'b1, 1'b0, 0, 0);

        // Stream 0..99 with both syncs held high.
        nxt = 0;
        budget = 0;
        while ((nxt < 100 || mq.size() != 0) && budget < 400) begin
            if (b_out_notify) got.push_back(int'(b_out));
            consumed = (mq.size() == 0);
            cycle(nxt, 1'b1, 1'b1);
            check_model($sformatf("stream_c%0d", budget));
            if (consumed && nxt < 100) nxt++;
            budget++;
        end
        n_cmp++;
        if (budget >= 400) begin
            n_bad++;
            $display("FAIL stream_timeout: got %0d cycles, required under 400", budget);
        end
        ok = (got.size() == 100);
        for (int k = 0; k < got.size(); k++) if (got[k] != k + 1) ok = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL stream_order: got %0d transfers (first %0d), required 100 values 1..100",
                     got.size(), (got.size() != 0) ? got[0] : -1);
        end
        n_cmp++;
        if (budget != 200 || m_out !== 32'd100) begin
            n_bad++;
            $display("FAIL stream_rate: got %0d cycles m_out=%0d, required 200 cycles m_out=100", budget, m_out);
        end

        // Randomised traffic against the model, with a mid-run reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rst = 1'b1;
                @(posedge clk);
                model_reset();
                @(negedge clk);
                check_model("rand_reset");
                rst = 1'b0;
            end
            cycle(int'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
